// File: rtl/fifo_inst.sv
// fifo_inst: single-clock circular-buffer FIFO with an occupancy counter.
// Any DEPTH >= 1 is supported; pointers wrap exactly at DEPTH-1.
// FALL_THROUGH=1 forwards data_i to data_o when the FIFO is empty.
// Optional macro FIFO_ASSERT_EN compiles in simulation-only protocol checks.
module fifo_inst #(
    parameter logic        FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    localparam int unsigned USAGE_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [USAGE_W-1:0]    usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [USAGE_W-1:0]    cnt;
    logic                  cnt_zero, ft, wr_en, rd_en;

    // testmode_i only matters once clock gating is added; tie it off here
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    assign cnt_zero = (cnt == '0);
    // fall-through window: empty FIFO with a word arriving this cycle
    assign ft       = FALL_THROUGH && cnt_zero && push_i;

    assign full_o   = (cnt == USAGE_W'(DEPTH));
    assign empty_o  = cnt_zero && !ft;
    assign usage_o  = cnt;
    assign data_o   = ft ? data_i : mem[rd_ptr];

    // a word that passes straight through is never stored; nothing is read
    // from storage while it is empty
    assign wr_en    = push_i && !full_o && !(ft && pop_i);
    assign rd_en    = pop_i && !cnt_zero;

    assign wr_nxt   = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    assign rd_nxt   = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);

    // pointers and occupancy; flush wins over any push/pop in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_nxt;
            if (rd_en) rd_ptr <= rd_nxt;
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + USAGE_W'(1);
                2'b01:   cnt <= cnt - USAGE_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // storage array, intentionally not reset
    always_ff @(posedge clk_i) begin
        if (wr_en && !flush_i) mem[wr_ptr] <= data_i;
    end

`ifdef FIFO_ASSERT_EN
    if (DEPTH == 0) begin : g_depth_chk
        $fatal(1, "fifo_inst: DEPTH must be at least 1");
    end

    a_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
        else $error("%m: push on full");
    a_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
        else $error("%m: pop on empty");
`endif

endmodule

// File: tb/tb_fifo_inst.sv
// tb_fifo_inst: self-checking bench for fifo_inst in four configurations
// (DEPTH 8, DEPTH 9, DEPTH 1 fall-through, DEPTH 1 normal) with scoreboard queues.
module tb_fifo_inst;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // a: DEPTH=8
    logic a_flush = 0, a_push = 0, a_pop = 0, a_full, a_empty;
    logic [7:0] a_din = 0, a_dout;
    logic [3:0] a_use;
    logic [7:0] a_q[$];
    // b: DEPTH=9
    logic b_flush = 0, b_push = 0, b_pop = 0, b_full, b_empty;
    logic [7:0] b_din = 0, b_dout;
    logic [3:0] b_use;
    logic [7:0] b_q[$];
    // c: DEPTH=1 fall-through
    logic c_flush = 0, c_push = 0, c_pop = 0, c_full, c_empty;
    logic [7:0] c_din = 0, c_dout;
    logic [0:0] c_use;
    // d: DEPTH=1 normal
    logic d_flush = 0, d_push = 0, d_pop = 0, d_full, d_empty;
    logic [7:0] d_din = 0, d_dout;
    logic [0:0] d_use;
    logic [7:0] d_q[$];

    fifo_inst #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(8)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .testmode_i(1'b0),
        .full_o(a_full), .empty_o(a_empty), .usage_o(a_use),
        .data_i(a_din), .push_i(a_push), .data_o(a_dout), .pop_i(a_pop));
    fifo_inst #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(9)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .testmode_i(1'b0),
        .full_o(b_full), .empty_o(b_empty), .usage_o(b_use),
        .data_i(b_din), .push_i(b_push), .data_o(b_dout), .pop_i(b_pop));
    fifo_inst #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .testmode_i(1'b0),
        .full_o(c_full), .empty_o(c_empty), .usage_o(c_use),
        .data_i(c_din), .push_i(c_push), .data_o(c_dout), .pop_i(c_pop));
    fifo_inst #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(1)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(d_flush), .testmode_i(1'b0),
        .full_o(d_full), .empty_o(d_empty), .usage_o(d_use),
        .data_i(d_din), .push_i(d_push), .data_o(d_dout), .pop_i(d_pop));

    // advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if ({a_empty, a_full, a_use} !== {1'b1, 1'b0, 4'd0}) begin n_err++; $display("FAIL reset_a got e%0b f%0b u%0d exp e1 f0 u0", a_empty, a_full, a_use); end
        n_cmp++; if ({b_empty, b_full, b_use} !== {1'b1, 1'b0, 4'd0}) begin n_err++; $display("FAIL reset_b got e%0b f%0b u%0d exp e1 f0 u0", b_empty, b_full, b_use); end
        n_cmp++; if ({c_empty, c_full, c_use} !== {1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL reset_c got e%0b f%0b u%0d exp e1 f0 u0", c_empty, c_full, c_use); end
        n_cmp++; if ({d_empty, d_full, d_use} !== {1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL reset_d got e%0b f%0b u%0d exp e1 f0 u0", d_empty, d_full, d_use); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            a_push = 1; a_din = 8'h11 + 8'(i); a_q.push_back(a_din);
            step();
        end
        a_push = 0; #1;
        n_cmp++; if (a_full !== 1'b1) begin n_err++; $display("FAIL fill_full got %0b exp 1", a_full); end
        n_cmp++; if (a_use !== 4'd8) begin n_err++; $display("FAIL fill_usage got %0d exp 8", a_use); end
        a_pop = 1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            exp = a_q.pop_front();
            n_cmp++; if (a_dout !== exp) begin n_err++; $display("FAIL drain_data[%0d] got %h exp %h", i, a_dout, exp); end
            step();
        end
        a_pop = 0; #1;
        n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %0b exp 1", a_empty); end
        n_cmp++; if (a_use !== 4'd0) begin n_err++; $display("FAIL drain_usage got %0d exp 0", a_use); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            a_push = 1; a_din = 8'h21 + 8'(i); a_q.push_back(a_din);
            step();
        end
        a_push = 1; a_pop = 1; a_din = 8'hAA; #1;
        exp = a_q.pop_front();
        n_cmp++; if (a_dout !== exp) begin n_err++; $display("FAIL fullpp_head got %h exp %h", a_dout, exp); end
        step();
        a_push = 0; a_pop = 0; #1;
        n_cmp++; if (a_use !== 4'd7) begin n_err++; $display("FAIL fullpp_usage got %0d exp 7", a_use); end
        n_cmp++; if (a_full !== 1'b0) begin n_err++; $display("FAIL fullpp_full got %0b exp 0", a_full); end
        a_pop = 1;
        while (a_q.size() > 0) begin
            exp = a_q.pop_front();
            n_cmp++; if (a_dout !== exp) begin n_err++; $display("FAIL fullpp_drain got %h exp %h", a_dout, exp); end
            step();
        end
        a_pop = 0; #1;
        n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL fullpp_empty got %0b exp 1", a_empty); end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 5; i++) begin
            a_push = 1; a_din = 8'h31 + 8'(i);
            step();
        end
        a_push = 0; #1;
        n_cmp++; if (a_use !== 4'd5) begin n_err++; $display("FAIL flush_pre_usage got %0d exp 5", a_use); end
        a_flush = 1; a_push = 1; a_din = 8'h99;
        step();
        a_flush = 0; a_push = 0; #1;
        n_cmp++; if (a_use !== 4'd0) begin n_err++; $display("FAIL flush_usage got %0d exp 0", a_use); end
        n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL flush_empty got %0b exp 1", a_empty); end
        a_push = 1; a_din = 8'h41;
        step();
        a_din = 8'h42;
        step();
        a_push = 0; #1;
        n_cmp++; if (a_dout !== 8'h41) begin n_err++; $display("FAIL postflush_head got %h exp 41", a_dout); end
        n_cmp++; if (a_use !== 4'd2) begin n_err++; $display("FAIL postflush_usage got %0d exp 2", a_use); end
        #2 rst_n = 1'b0; #1;
        n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL async_rst_empty got %0b exp 1", a_empty); end
        n_cmp++; if (a_use !== 4'd0) begin n_err++; $display("FAIL async_rst_usage got %0d exp 0", a_use); end
        step();
        rst_n = 1'b1;
        step();
        a_q.delete();
    endtask

    task automatic test_depth1();
        logic [7:0] exp;
        d_push = 1; d_din = 8'h3C; d_q.push_back(d_din);
        step();
        d_push = 0; #1;
        n_cmp++; if (d_full !== 1'b1) begin n_err++; $display("FAIL d1_full got %0b exp 1", d_full); end
        n_cmp++; if (d_empty !== 1'b0) begin n_err++; $display("FAIL d1_notempty got %0b exp 0", d_empty); end
        n_cmp++; if (d_dout !== 8'h3C) begin n_err++; $display("FAIL d1_data got %h exp 3c", d_dout); end
        // push while full with pop: the push must be dropped
        d_pop = 1; d_push = 1; d_din = 8'hE7;
        exp = d_q.pop_front();
        n_cmp++; if (d_dout !== exp) begin n_err++; $display("FAIL d1_pop_data got %h exp %h", d_dout, exp); end
        step();
        d_pop = 0; d_push = 0; #1;
        n_cmp++; if (d_empty !== 1'b1) begin n_err++; $display("FAIL d1_empty got %0b exp 1", d_empty); end
        n_cmp++; if (d_full !== 1'b0) begin n_err++; $display("FAIL d1_notfull got %0b exp 0", d_full); end
        // continuous push/pop: one word per two cycles
        for (int i = 0; i < 8; i++) begin
            logic acc_push, acc_pop;
            d_push = 1; d_pop = 1; d_din = 8'h50 + 8'(i); #1;
            acc_pop  = (d_q.size() > 0);
            acc_push = (d_q.size() < 1);
            if (acc_pop) begin
                exp = d_q.pop_front();
                n_cmp++; if (d_dout !== exp) begin n_err++; $display("FAIL d1_b2b_data got %h exp %h", d_dout, exp); end
            end
            if (acc_push) d_q.push_back(d_din);
            step();
        end
        d_push = 0; d_pop = 0; #1;
        n_cmp++; if (d_use !== 1'(d_q.size())) begin n_err++; $display("FAIL d1_b2b_usage got %0d exp %0d", d_use, d_q.size()); end
    endtask

    task automatic test_fall_through();
        c_push = 1; c_pop = 1; c_din = 8'h5A; #1;
        n_cmp++; if (c_dout !== 8'h5A) begin n_err++; $display("FAIL ft_pass_data got %h exp 5a", c_dout); end
        n_cmp++; if (c_empty !== 1'b0) begin n_err++; $display("FAIL ft_pass_empty got %0b exp 0", c_empty); end
        step();
        c_push = 0; c_pop = 0; #1;
        n_cmp++; if (c_use !== 1'b0) begin n_err++; $display("FAIL ft_pass_usage got %0d exp 0", c_use); end
        n_cmp++; if (c_empty !== 1'b1) begin n_err++; $display("FAIL ft_pass_empty2 got %0b exp 1", c_empty); end
        c_push = 1; c_din = 8'h6B; #1;
        n_cmp++; if (c_dout !== 8'h6B) begin n_err++; $display("FAIL ft_store_fwd got %h exp 6b", c_dout); end
        step();
        c_push = 0; #1;
        n_cmp++; if (c_full !== 1'b1) begin n_err++; $display("FAIL ft_store_full got %0b exp 1", c_full); end
        n_cmp++; if (c_dout !== 8'h6B) begin n_err++; $display("FAIL ft_store_data got %h exp 6b", c_dout); end
        c_push = 1; c_pop = 1; c_din = 8'h7C; #1;
        n_cmp++; if (c_dout !== 8'h6B) begin n_err++; $display("FAIL ft_full_head got %h exp 6b", c_dout); end
        step();
        c_push = 0; c_pop = 0; #1;
        n_cmp++; if (c_empty !== 1'b1) begin n_err++; $display("FAIL ft_full_drop got %0b exp 1", c_empty); end
        for (int i = 0; i < 4; i++) begin
            c_push = 1; c_pop = 1; c_din = 8'h80 + 8'(i); #1;
            n_cmp++; if (c_dout !== c_din || c_empty !== 1'b0) begin n_err++; $display("FAIL ft_b2b[%0d] got %h/e%0b exp %h/e0", i, c_dout, c_empty, c_din); end
            step();
        end
        c_push = 0; c_pop = 0; #1;
        n_cmp++; if (c_use !== 1'b0) begin n_err++; $display("FAIL ft_b2b_usage got %0d exp 0", c_use); end
    endtask

    task automatic test_random();
        int pushes = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic acc_push, acc_pop;
            logic [7:0] exp;
            int fill_bias;
            fill_bias = ((cyc / 150) % 2 == 0) ? 3 : 1;
            b_push = ($urandom_range(0, 3) < fill_bias);
            b_pop  = ($urandom_range(0, 3) >= fill_bias);
            b_din  = 8'($urandom);
            #1;
            n_cmp++; if (b_use !== 4'(b_q.size()) || b_full !== (b_q.size() == 9) || b_empty !== (b_q.size() == 0)) begin
                n_err++; $display("FAIL rand_flags cyc %0d got u%0d f%0b e%0b exp u%0d", cyc, b_use, b_full, b_empty, b_q.size());
            end
            acc_push = b_push && (b_q.size() < 9);
            acc_pop  = b_pop && (b_q.size() > 0);
            if (acc_pop) begin
                exp = b_q.pop_front();
                n_cmp++; if (b_dout !== exp) begin n_err++; $display("FAIL rand_data cyc %0d got %h exp %h", cyc, b_dout, exp); end
            end
            if (acc_push) begin
                b_q.push_back(b_din);
                pushes++;
            end
            step();
        end
        b_push = 0; b_pop = 0;
        $display("random test: %0d words pushed into DEPTH=9 instance", pushes);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_flush_reset();
        test_depth1();
        test_fall_through();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
